// File: rtl/count_pkg.sv
// Shared definitions for the count sequencing controller: state encoding,
// button indices, LED bit map and the prescaler period helper.
package count_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_UP   = 4'b0010,
        ST_DOWN = 4'b0100,
        ST_HALT = 4'b1000
    } state_t;

    localparam int unsigned BTN_RUN = 0;
    localparam int unsigned BTN_DIR = 1;
    localparam int unsigned BTN_CLR = 2;

    localparam int unsigned LED_WRAP = 10;
    localparam int unsigned LED_DIR  = 11;
    localparam int unsigned LED_IDLE = 12;
    localparam int unsigned LED_UP   = 13;
    localparam int unsigned LED_DOWN = 14;
    localparam int unsigned LED_HALT = 15;

    localparam int unsigned PRESC_W = 16;

    // Ticks per count step for a 4-bit rate select.
    function automatic logic [PRESC_W-1:0] rate_period(input logic [3:0] sel,
                                                       input int unsigned unit);
        return PRESC_W'((32'(sel) + 32'd1) * unit);
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Tick prescaler: counts enabled ticks and strobes step once per period.
module step_prescaler #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         enable,
    input  logic         clear,
    input  logic [W-1:0] period,
    output logic         step
);

    logic [W-1:0] cnt;
    logic         reached;

    // >= rather than == so a shortened period steps on the very next tick.
    always_comb begin
        reached = (cnt >= (period - W'(1)));
        step    = enable && tick && reached && !clear;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && tick) begin
            if (reached) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/count_seq_ctrl.sv
// Sequencing controller: button edge commands, run/direction FSM and
// wrap/saturate count arithmetic feeding the FND controller.
module count_seq_ctrl #(
    parameter int unsigned MAX_COUNT     = 9999,
    parameter int unsigned TICK_DIV_UNIT = 10
) (
    input  logic        clk_100Mhz,
    input  logic        rst,
    input  logic        tick,
    input  logic [2:0]  btnDb,
    input  logic [7:0]  sw,
    output logic [15:0] led,
    output logic [13:0] segData
);

    import count_pkg::*;

    state_t             state;
    logic               dir;
    logic [13:0]        count;
    logic [2:0]         btn_q;
    logic [2:0]         rise;
    logic               step;
    logic               run_en;
    logic [PRESC_W-1:0] period;
    logic [14:0]        s;
    logic [14:0]        max15;
    logic [14:0]        cur;
    logic [14:0]        up_sum;
    logic [14:0]        step_val;
    logic               bound_hit;
    logic [15:0]        led_nxt;

    always_comb begin
        rise   = btnDb & ~btn_q;
        run_en = (state == ST_UP) || (state == ST_DOWN);
        period = rate_period(sw[3:0], TICK_DIV_UNIT);
    end

    // Any accepted command also zeroes the prescaler, which suppresses a
    // coincident step.
    step_prescaler #(
        .W (PRESC_W)
    ) u_presc (
        .clk    (clk_100Mhz),
        .rst    (rst),
        .tick   (tick),
        .enable (run_en),
        .clear  (|rise),
        .period (period),
        .step   (step)
    );

    always_comb begin
        s         = sw[4] ? 15'd10 : 15'd1;
        max15     = 15'(MAX_COUNT);
        cur       = {1'b0, count};
        up_sum    = cur + s;
        step_val  = '0;
        bound_hit = 1'b0;
        if (state == ST_UP) begin
            if (up_sum <= max15) begin
                step_val = up_sum;
            end else if (sw[7]) begin
                step_val = up_sum - (max15 + 15'd1);
            end else begin
                step_val  = max15;
                bound_hit = 1'b1;
            end
        end else begin
            if (cur >= s) begin
                step_val = cur - s;
            end else if (sw[7]) begin
                step_val = cur + (max15 + 15'd1) - s;
            end else begin
                step_val  = '0;
                bound_hit = 1'b1;
            end
        end
    end

    always_comb begin
        led_nxt           = '0;
        led_nxt[LED_IDLE] = (state == ST_IDLE);
        led_nxt[LED_UP]   = (state == ST_UP);
        led_nxt[LED_DOWN] = (state == ST_DOWN);
        led_nxt[LED_HALT] = (state == ST_HALT);
        led_nxt[LED_DIR]  = dir;
        led_nxt[LED_WRAP] = sw[7];
        led_nxt[9:0]      = count[9:0];
    end

    always_ff @(posedge clk_100Mhz) begin
        if (rst) begin
            state   <= ST_IDLE;
            dir     <= 1'b1;
            count   <= '0;
            btn_q   <= '0;
            led     <= 16'h1800;
            segData <= '0;
        end else begin
            btn_q   <= btnDb;
            led     <= led_nxt;
            segData <= count;
            if (rise[BTN_CLR]) begin
                count <= '0;
                state <= ST_IDLE;
            end else if (rise[BTN_RUN]) begin
                if (state == ST_IDLE) begin
                    state <= dir ? ST_UP : ST_DOWN;
                end else begin
                    state <= ST_IDLE;
                end
            end else if (rise[BTN_DIR]) begin
                dir <= ~dir;
                if (state != ST_IDLE) begin
                    state <= dir ? ST_DOWN : ST_UP;
                end
            end else if (step) begin
                count <= step_val[13:0];
                if (bound_hit) begin
                    state <= ST_HALT;
                end
            end
        end
    end

endmodule

// File: doc/count_seq_ctrl.md
# count_seq_ctrl

Sequencing controller for the up/down counter datapath. Sits between `debounce` and `fndCtrl` and is driven by the shared 1 kHz `tick`. It turns debounced button presses into run, stop, direction and clear commands, and paces count steps with a switch-selected prescaler. It applies wrap or saturate rules at the 0/MAX bounds and drives status LEDs plus the binary count to the FND controller.

## Interface
- `MAX_COUNT`, default 9999: upper count bound; must fit in 14 bits.
- `TICK_DIV_UNIT`, default 10: ticks per rate unit.
- `clk_100Mhz`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `tick`  in  1  one-cycle strobe at 1 kHz.
- `btnDb`  in  3  debounced, level buttons: [0] run/stop, [1] direction toggle, [2] clear.
- `sw`  in  8  [3:0] rate select, [4] step ×10, [7] wrap enable; [6:5] unused.
- `led`  out  16  status, registered.
- `segData`  out  14  current count in binary, registered.

## Operation
- Rising-edge detect on each `btnDb` bit against a registered copy. One press produces exactly one command, regardless of hold length.
- States:
  - IDLE: holding.
  - RUN_UP
  - RUN_DOWN
  - HALT: bound reached in saturate mode.
- `dir` register: 1 means up.
- Transitions:
  - IDLE: run → RUN_UP if dir=1, else RUN_DOWN.
  - RUN_x: run → IDLE. Dir toggle flips `dir` and moves to the other RUN state.
  - IDLE: dir toggle flips `dir` only.
  - HALT: run → IDLE. Dir toggle flips `dir` and enters the matching RUN state.
  - Clear from any state: count=0, prescaler=0, state → IDLE, `dir` unchanged.
- Simultaneous edges, priority order: clear > run/stop > dir toggle. Lower-priority edges in the same cycle are dropped.
- Prescaler:
  - Counts `tick` only while in RUN_x.
  - Period P = (`sw[3:0]`+1)·`TICK_DIV_UNIT` ticks, range 10..160.
  - On a tick with prescaler ≥ P−1: step the count and zero the prescaler. Otherwise increment the prescaler.
  - The ≥ compare lets a rate change mid-period step on the next tick.
  - Prescaler is zeroed on every state change.
- Step size s = 10 if `sw[4]`, else 1. All bound arithmetic is 15-bit, so there is no overflow.
- Counting up:
  - count+s ≤ MAX → count+s.
  - Otherwise, wrap mode → count+s−(MAX+1).
  - Otherwise, saturate mode → MAX and state → HALT.
- Counting down:
  - count ≥ s → count−s.
  - Otherwise, wrap mode → count+(MAX+1)−s.
  - Otherwise, saturate mode → 0 and state → HALT.
- `sw` is sampled live each cycle and needs no synchronizer (quasi-static).
- `led` bit map:
  - [12] IDLE, [13] RUN_UP, [14] RUN_DOWN, [15] HALT (one-hot state).
  - [11] `dir`.
  - [10] `sw[7]`.
  - [9:0] count[9:0].
- `segData` = count.

## Timing
- Reset values: state IDLE, `dir`=1, count 0, prescaler 0, edge regs 0, `led`=16'h1800 (with `sw[7]`=0), `segData`=0.
- Reset asserted mid-run takes effect at the next edge and overrides every command.
- Button rises before edge k → state updates at edge k. `led` and `segData` reflect it after edge k+1 (one register stage).
- A step occurs on the edge where `tick`=1 and the prescaler matches. The new count appears on `segData` one cycle later.
- Entering RUN from IDLE: first step happens exactly P ticks later.
- A button press in the same cycle as a step tick: the command wins. The step is suppressed and the prescaler is zeroed.

## Structure
- Shared package `count_pkg`:
  - State encoding constants `ST_IDLE`/`ST_UP`/`ST_DOWN`/`ST_HALT` (one-hot, 4 bits).
  - Button index constants `BTN_RUN`=0, `BTN_DIR`=1, `BTN_CLR`=2.
  - LED bit positions.
- One sub-module: `step_prescaler`. Inputs: tick, enable, clear, period. Output: step strobe.
- FSM, edge detect and count arithmetic live in `count_seq_ctrl`.

## Test plan
- Reset, then IDLE: `led`=16'h1800, `segData`=0. Ten ticks produce no count change.
- `sw`=8'h00, one run press → RUN_UP. After 50 ticks `segData`=5 and `led[13]`=1. A held button produces no further commands.
- `sw`=8'h80 (wrap), count at 9999, one step → 0. Then a dir press and one step → 9999.
- `sw`=8'h10 (saturate, ×10), count 9995 up → 9999 and HALT (`led[15]`=1). A dir press then resumes RUN_DOWN, and the next step gives 9989.
- Clear and run edges in the same cycle while in RUN_UP at count 42 → count 0, IDLE.
- Mid-run, change `sw[3:0]` from 15 to 0 with the prescaler at 80 → step on the next tick, then every 10 ticks. Assert `rst` mid-run → reset values restored on the next edge.
